uart_tx_frame: RTL

//  Parametrised UART transmitter; successor to the fixed 8N1 byte transmitter.

---
 rtl/uart_pkg.sv | 20 ++
 rtl/uart_baud_tick.sv | 29 ++
 rtl/uart_tx_frame.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared types and parameter-legality helpers for the UART blocks.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_tx_state_t;

  function automatic bit legalDataBits(input int n);
    return (n >= 5) && (n <= 9);
  endfunction

  function automatic bit legalStopBits(input int n);
    return (n >= 1) && (n <= 2);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period timer: counts clock cycles within one bit, bitEnd on the last cycle.
module uart_baud_tick #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic bitEnd
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST_COUNT = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] count;

  assign bitEnd = (count == LAST_COUNT);

  // Wrapping at bitEnd restarts timing exactly on every bit boundary.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear || bitEnd) begin
      count <= '0;
    end else begin
      count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/uart_tx_frame.sv
// Parametrised UART transmitter: start, DATA_BITS LSB first, optional parity, 1-2 stops.
// Define UART_TX_PARITY_EN to insert the parity bit (PARITY_ODD selects odd parity).
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD       = 115200,
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 txValid,
  input  logic [DATA_BITS-1:0] txData,
  output logic                 txReady,
  output logic                 uartTxBit,
  output logic                 uartTxDone,
  output logic                 txBusy
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int DCW = $clog2(DATA_BITS);
  localparam logic [DCW-1:0] LAST_DATA = DCW'(DATA_BITS - 1);
  localparam logic LAST_STOP = 1'(STOP_BITS - 1);

  generate
    if (CLKS_PER_BIT < 2) begin : gBadBaud
      $error("uart_tx_frame: CLKS_PER_BIT must be at least 2");
    end
    if (!legalDataBits(DATA_BITS)) begin : gBadData
      $error("uart_tx_frame: DATA_BITS must be 5..9");
    end
    if (!legalStopBits(STOP_BITS)) begin : gBadStop
      $error("uart_tx_frame: STOP_BITS must be 1..2");
    end
  endgenerate

  uart_tx_state_t       state;
  logic [DATA_BITS-1:0] shiftReg;
  logic [DCW-1:0]       dataCnt;
  logic                 stopCnt;
  logic                 bitEnd;
  logic                 baudClear;
  logic                 lastStop;
  logic                 accept;
`ifdef UART_TX_PARITY_EN
  logic                 parityBit;
`endif

  assign baudClear = (state == IDLE);

  uart_baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) baudTick (
    .clk    (clk),
    .reset  (reset),
    .clear  (baudClear),
    .bitEnd (bitEnd)
  );

  // The final cycle of the last stop bit doubles as the acceptance slot for gapless frames.
  assign lastStop   = (state == STOP) && bitEnd && (stopCnt == LAST_STOP);
  assign txReady    = (state == IDLE) || lastStop;
  assign uartTxDone = lastStop;
  assign txBusy     = (state != IDLE);
  assign accept     = txValid && txReady;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      shiftReg  <= '0;
      dataCnt   <= '0;
      stopCnt   <= 1'b0;
      uartTxBit <= 1'b1;
`ifdef UART_TX_PARITY_EN
      parityBit <= 1'b0;
`endif
    end else if (accept) begin
      state     <= START;
      shiftReg  <= txData;
      dataCnt   <= '0;
      stopCnt   <= 1'b0;
      uartTxBit <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parityBit <= (^txData) ^ (PARITY_ODD != 0);
`endif
    end else begin
      case (state)
        IDLE: begin
          uartTxBit <= 1'b1;
        end
        START: begin
          if (bitEnd) begin
            state     <= DATA;
            dataCnt   <= '0;
            uartTxBit <= shiftReg[0];
          end
        end
        DATA: begin
          if (bitEnd) begin
            if (dataCnt == LAST_DATA) begin
`ifdef UART_TX_PARITY_EN
              state     <= PARITY;
              uartTxBit <= parityBit;
`else
              state     <= STOP;
              stopCnt   <= 1'b0;
              uartTxBit <= 1'b1;
`endif
            end else begin
              dataCnt   <= dataCnt + DCW'(1);
              shiftReg  <= shiftReg >> 1;
              uartTxBit <= shiftReg[1];
            end
          end
        end
        PARITY: begin
`ifdef UART_TX_PARITY_EN
          if (bitEnd) begin
            state     <= STOP;
            stopCnt   <= 1'b0;
            uartTxBit <= 1'b1;
          end
`else
          state     <= IDLE;
          uartTxBit <= 1'b1;
`endif
        end
        STOP: begin
          if (lastStop) begin
            state     <= IDLE;
            uartTxBit <= 1'b1;
          end else if (bitEnd) begin
            stopCnt <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          uartTxBit <= 1'b1;
        end
      endcase
    end
  end

endmodule
